// File: rtl/spi_flash_responder_pkg.sv
// rtl/spi_flash_responder_pkg.sv - shared opcodes, command width and FSM states
package spi_flash_responder_pkg;

  localparam int CMD_WIDTH = 8;
  localparam logic [CMD_WIDTH-1:0] CMD_READ  = 8'h03;
  localparam logic [CMD_WIDTH-1:0] CMD_WRITE = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_RD_DATA,
    ST_WR_DATA,
    ST_IGNORE
  } state_e;

endpackage

// File: rtl/spi_in_sync.sv
// rtl/spi_in_sync.sv - N-stage synchronizer with a history flop for rise/fall pulses
module spi_in_sync #(
  parameter int P_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [P_STAGES-1:0] sync_q;
  logic                hist_q;

  // Reset low so a line already high at release shows up as a rising edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[P_STAGES-2:0], i_async};
      hist_q <= sync_q[P_STAGES-1];
    end
  end

  assign o_level = sync_q[P_STAGES-1];
  assign o_rise  = o_level & ~hist_q;
  assign o_fall  = ~o_level & hist_q;

endmodule

// File: rtl/spi_flash_responder.sv
// rtl/spi_flash_responder.sv - SPI mode-0 flash stand-in: decodes cmd+addr, streams memory reads/writes
module spi_flash_responder
  import spi_flash_responder_pkg::*;
#(
  parameter int                   P_ADDR_WIDTH  = 24,
  parameter int                   P_DATA_WIDTH  = 8,
  parameter logic [CMD_WIDTH-1:0] P_CMD_READ    = CMD_READ,
  parameter logic [CMD_WIDTH-1:0] P_CMD_WRITE   = CMD_WRITE,
  parameter int                   P_SYNC_STAGES = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_spi_clk,
  input  logic                    i_spi_cs,
  input  logic                    i_spi_mosi,
  output logic                    o_spi_miso,
  output logic                    o_spi_miso_oe,
  output logic [P_ADDR_WIDTH-1:0] o_mem_addr,
  output logic                    o_mem_rd_req,
  input  logic [P_DATA_WIDTH-1:0] i_mem_rd_data,
  output logic [P_DATA_WIDTH-1:0] o_mem_wr_data,
  output logic                    o_mem_wr_valid,
  output logic [CMD_WIDTH-1:0]    o_cmd,
  output logic                    o_cmd_valid,
  output logic                    o_busy
);

  localparam logic [5:0] CMD_LAST  = 6'(CMD_WIDTH - 1);
  localparam logic [5:0] ADDR_LAST = 6'(P_ADDR_WIDTH - 1);
  localparam logic [5:0] DATA_LAST = 6'(P_DATA_WIDTH - 1);

  logic sclk_level, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;
  logic [P_SYNC_STAGES-1:0] mosi_q;
  logic mosi;

  state_e state_q, state_d;
  logic [5:0]              bit_cnt_q;
  logic [P_DATA_WIDTH-2:0] rx_q;
  logic [P_DATA_WIDTH-1:0] tx_q;
  logic                    miso_q;
  logic                    load_q;
  logic                    armed_q;
  logic [CMD_WIDTH-1:0]    cmd_next;
  logic                    cmd_ok;

  spi_in_sync #(.P_STAGES(P_SYNC_STAGES)) u_sclk_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_spi_clk),
    .o_level (sclk_level),
    .o_rise  (sclk_rise),
    .o_fall  (sclk_fall)
  );

  spi_in_sync #(.P_STAGES(P_SYNC_STAGES)) u_cs_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_spi_cs),
    .o_level (cs_level),
    .o_rise  (cs_rise),
    .o_fall  (cs_fall)
  );

  // Same depth as the SCLK chain so the sampled bit lines up with sclk_rise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) mosi_q <= '0;
    else          mosi_q <= {mosi_q[P_SYNC_STAGES-2:0], i_spi_mosi};
  end
  assign mosi = mosi_q[P_SYNC_STAGES-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    cmd_next = {rx_q[CMD_WIDTH-2:0], mosi};
    cmd_ok   = (cmd_next == P_CMD_READ) || (cmd_next == P_CMD_WRITE);
    state_d  = state_q;
    if (cs_level) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        // A frame only starts once a full CS high->low has been seen with SCLK idle low.
        ST_IDLE: if (cs_fall && armed_q && !sclk_level) state_d = ST_CMD;
        ST_CMD:  if (sclk_rise && bit_cnt_q == CMD_LAST)
                   state_d = cmd_ok ? ST_ADDR : ST_IGNORE;
        ST_ADDR: if (sclk_rise && bit_cnt_q == ADDR_LAST)
                   state_d = (o_cmd == P_CMD_READ) ? ST_RD_DATA : ST_WR_DATA;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bit_cnt_q      <= '0;
      rx_q           <= '0;
      tx_q           <= '0;
      miso_q         <= 1'b0;
      load_q         <= 1'b0;
      armed_q        <= 1'b0;
      o_mem_addr     <= '0;
      o_mem_rd_req   <= 1'b0;
      o_mem_wr_data  <= '0;
      o_mem_wr_valid <= 1'b0;
      o_cmd          <= '0;
      o_cmd_valid    <= 1'b0;
    end else begin
      o_mem_rd_req   <= 1'b0;
      o_mem_wr_valid <= 1'b0;
      o_cmd_valid    <= 1'b0;
      load_q         <= o_mem_rd_req;
      if (cs_rise) armed_q <= 1'b1;
      if (o_mem_wr_valid) o_mem_addr <= o_mem_addr + 1'b1;

      if (load_q) begin
        tx_q <= i_mem_rd_data;
      end else if (sclk_fall && state_q == ST_RD_DATA) begin
        miso_q <= tx_q[P_DATA_WIDTH-1];
        tx_q   <= {tx_q[P_DATA_WIDTH-2:0], 1'b0};
      end

      // CS high takes priority over a coincident SCLK edge, dropping that bit.
      if (cs_level) begin
        bit_cnt_q <= '0;
      end else if (sclk_rise) begin
        case (state_q)
          ST_CMD: begin
            rx_q      <= cmd_next[P_DATA_WIDTH-2:0];
            bit_cnt_q <= (bit_cnt_q == CMD_LAST) ? '0 : bit_cnt_q + 1'b1;
            if (bit_cnt_q == CMD_LAST) begin
              o_cmd       <= cmd_next;
              o_cmd_valid <= !cmd_ok;
            end
          end
          ST_ADDR: begin
            o_mem_addr <= {o_mem_addr[P_ADDR_WIDTH-2:0], mosi};
            bit_cnt_q  <= (bit_cnt_q == ADDR_LAST) ? '0 : bit_cnt_q + 1'b1;
            if (bit_cnt_q == ADDR_LAST && o_cmd == P_CMD_READ) o_mem_rd_req <= 1'b1;
          end
          ST_RD_DATA: begin
            bit_cnt_q <= (bit_cnt_q == DATA_LAST) ? '0 : bit_cnt_q + 1'b1;
            if (bit_cnt_q == DATA_LAST) begin
              o_mem_addr   <= o_mem_addr + 1'b1;
              o_mem_rd_req <= 1'b1;
            end
          end
          ST_WR_DATA: begin
            rx_q      <= {rx_q[P_DATA_WIDTH-3:0], mosi};
            bit_cnt_q <= (bit_cnt_q == DATA_LAST) ? '0 : bit_cnt_q + 1'b1;
            if (bit_cnt_q == DATA_LAST) begin
              o_mem_wr_data  <= {rx_q, mosi};
              o_mem_wr_valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_spi_miso_oe = (state_q == ST_RD_DATA);
  assign o_spi_miso    = o_spi_miso_oe & miso_q;
  assign o_busy        = armed_q & ~cs_level;

endmodule

// File: tb/tb_spi_flash_responder.sv
// tb/tb_spi_flash_responder.sv - randomized self-checking bench for spi_flash_responder
module tb_spi_flash_responder;

  localparam int H = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_clk = 1'b0;
  logic        spi_cs = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        miso, miso_oe;
  logic [23:0] mem_addr;
  logic        rd_req;
  logic [7:0]  rd_data;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic [7:0]  cmd;
  logic        cmd_valid;
  logic        busy;
  wire  [45:0] all_outs = {miso, miso_oe, mem_addr, rd_req, wr_data, wr_valid, cmd, cmd_valid, busy};

  int checks = 0;
  int failures = 0;
  int oe_bad = 0;
  int oe_missing = 0;
  logic oe_forbid = 1'b1;
  logic data_phase = 1'b0;
  logic [23:0] rd_q[$];
  logic [31:0] wr_q[$];
  logic [7:0]  cv_q[$];
  logic [7:0]  tx_bytes[$];

  always #5 clk = ~clk;

  spi_flash_responder dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_spi_clk      (spi_clk),
    .i_spi_cs       (spi_cs),
    .i_spi_mosi     (spi_mosi),
    .o_spi_miso     (miso),
    .o_spi_miso_oe  (miso_oe),
    .o_mem_addr     (mem_addr),
    .o_mem_rd_req   (rd_req),
    .i_mem_rd_data  (rd_data),
    .o_mem_wr_data  (wr_data),
    .o_mem_wr_valid (wr_valid),
    .o_cmd          (cmd),
    .o_cmd_valid    (cmd_valid),
    .o_busy         (busy)
  );

  function automatic logic [7:0] mem_f(input logic [23:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  // Memory model and event log: data answers the request on the following cycle.
  initial begin
    rd_data = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rd_req) begin
          rd_q.push_back(mem_addr);
          rd_data = mem_f(mem_addr);
        end
        if (wr_valid) wr_q.push_back({mem_addr, wr_data});
        if (cmd_valid) cv_q.push_back(cmd);
        if (oe_forbid && miso_oe) oe_bad++;
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    rd_q.delete();
    wr_q.delete();
    cv_q.delete();
    oe_bad = 0;
    oe_missing = 0;
  endtask

  task automatic spi_bit(input logic b, output logic m);
    spi_mosi = b;
    wait_clks(H);
    m = miso;
    if (data_phase && miso_oe !== 1'b1) oe_missing++;
    spi_clk = 1'b1;
    wait_clks(H);
    spi_clk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic m;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], m);
      rx[i] = m;
    end
  endtask

  task automatic spi_begin();
    spi_cs = 1'b0;
    wait_clks(H);
  endtask

  task automatic spi_end();
    wait_clks(H);
    spi_cs = 1'b1;
    wait_clks(2 * H);
  endtask

  task automatic do_read(input logic [23:0] start, input int n, input string name);
    logic [7:0] rx, exp, dummy;
    clear_log();
    oe_forbid = 1'b1;
    spi_begin();
    spi_byte(8'h03, dummy);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL %s_busy: got %b want 1", name, busy);
    end
    spi_byte(start[23:16], dummy);
    spi_byte(start[15:8], dummy);
    oe_forbid = 1'b0;
    spi_byte(start[7:0], dummy);
    data_phase = 1'b1;
    for (int i = 0; i < n; i++) begin
      spi_byte(8'($urandom), rx);
      exp = mem_f(24'(start + i));
      checks++;
      if (rx !== exp) begin
        failures++;
        $display("FAIL %s_miso[%0d]: got %h want %h", name, i, rx, exp);
      end
    end
    data_phase = 1'b0;
    spi_end();
    oe_forbid = 1'b1;
    checks++;
    if (rd_q.size() != n + 1) begin
      failures++;
      $display("FAIL %s_rd_count: got %0d want %0d", name, rd_q.size(), n + 1);
    end else begin
      for (int i = 0; i <= n; i++) begin
        checks++;
        if (rd_q[i] !== 24'(start + i)) begin
          failures++;
          $display("FAIL %s_rd_addr[%0d]: got %h want %h", name, i, rd_q[i], 24'(start + i));
        end
      end
    end
    checks++;
    if (wr_q.size() != 0 || cv_q.size() != 0) begin
      failures++;
      $display("FAIL %s_stray: got wr=%0d cv=%0d want 0 0", name, wr_q.size(), cv_q.size());
    end
    checks++;
    if (oe_bad != 0 || oe_missing != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_oe_busy: got oe_bad=%0d oe_missing=%0d busy=%b want 0 0 0", name, oe_bad, oe_missing, busy);
    end
  endtask

  task automatic do_write(input logic [23:0] start, input string name);
    logic [7:0] dummy;
    clear_log();
    oe_forbid = 1'b1;
    spi_begin();
    spi_byte(8'h02, dummy);
    spi_byte(start[23:16], dummy);
    spi_byte(start[15:8], dummy);
    spi_byte(start[7:0], dummy);
    foreach (tx_bytes[i]) spi_byte(tx_bytes[i], dummy);
    spi_end();
    checks++;
    if (wr_q.size() != tx_bytes.size()) begin
      failures++;
      $display("FAIL %s_wr_count: got %0d want %0d", name, wr_q.size(), tx_bytes.size());
    end else begin
      foreach (tx_bytes[i]) begin
        checks++;
        if (wr_q[i] !== {24'(start + i), tx_bytes[i]}) begin
          failures++;
          $display("FAIL %s_wr[%0d]: got %h want %h", name, i, wr_q[i], {24'(start + i), tx_bytes[i]});
        end
      end
    end
    checks++;
    if (rd_q.size() != 0 || cv_q.size() != 0 || oe_bad != 0) begin
      failures++;
      $display("FAIL %s_stray: got rd=%0d cv=%0d oe_bad=%0d want 0 0 0", name, rd_q.size(), cv_q.size(), oe_bad);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_clks(3);
    checks++;
    if (all_outs !== 46'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h want 0", all_outs);
    end
    rst_n = 1'b1;
    wait_clks(10);
    checks++;
    if (all_outs !== 46'd0) begin
      failures++;
      $display("FAIL post_reset_outputs: got %h want 0", all_outs);
    end
  endtask

  task automatic test_read_stream();
    do_read(24'h000010, 3, "read_stream");
  endtask

  task automatic test_write_wrap();
    tx_bytes.delete();
    tx_bytes.push_back(8'h5A);
    tx_bytes.push_back(8'hC3);
    tx_bytes.push_back(8'h11);
    do_write(24'hFFFFFE, "write_wrap");
  endtask

  task automatic test_unknown(input logic [7:0] op);
    logic [7:0] dummy;
    clear_log();
    oe_forbid = 1'b1;
    spi_begin();
    spi_byte(op, dummy);
    spi_byte(8'($urandom), dummy);
    spi_byte(8'($urandom), dummy);
    spi_end();
    checks++;
    if (cv_q.size() != 1 || cmd !== op) begin
      failures++;
      $display("FAIL unknown_cmd_valid: got pulses=%0d cmd=%h want 1 %h", cv_q.size(), cmd, op);
    end else begin
      checks++;
      if (cv_q[0] !== op) begin
        failures++;
        $display("FAIL unknown_cmd_at_pulse: got %h want %h", cv_q[0], op);
      end
    end
    checks++;
    if (rd_q.size() != 0 || wr_q.size() != 0 || oe_bad != 0) begin
      failures++;
      $display("FAIL unknown_stray: got rd=%0d wr=%0d oe_bad=%0d want 0 0 0", rd_q.size(), wr_q.size(), oe_bad);
    end
  endtask

  task automatic test_abort();
    logic [7:0] dummy;
    logic m;
    clear_log();
    oe_forbid = 1'b1;
    spi_begin();
    spi_byte(8'h03, dummy);
    for (int i = 0; i < 20; i++) spi_bit(1'($urandom), m);
    spi_end();
    checks++;
    if (rd_q.size() != 0 || wr_q.size() != 0 || cv_q.size() != 0 || oe_bad != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_quiet: got rd=%0d wr=%0d cv=%0d oe_bad=%0d busy=%b want all 0",
               rd_q.size(), wr_q.size(), cv_q.size(), oe_bad, busy);
    end
    do_read(24'h000000, 2, "abort_recover");
  endtask

  task automatic test_partial_write();
    logic [7:0] dummy;
    logic m;
    clear_log();
    oe_forbid = 1'b1;
    spi_begin();
    spi_byte(8'h02, dummy);
    spi_byte(8'h00, dummy);
    spi_byte(8'h01, dummy);
    spi_byte(8'h00, dummy);
    spi_byte(8'hAA, dummy);
    for (int i = 0; i < 5; i++) spi_bit(1'($urandom), m);
    spi_end();
    checks++;
    if (wr_q.size() != 1) begin
      failures++;
      $display("FAIL partial_wr_count: got %0d want 1", wr_q.size());
    end else begin
      checks++;
      if (wr_q[0] !== 32'h000100AA) begin
        failures++;
        $display("FAIL partial_wr_entry: got %h want 000100aa", wr_q[0]);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] dummy;
    logic m;
    clear_log();
    oe_forbid = 1'b0;
    spi_begin();
    spi_byte(8'h03, dummy);
    spi_byte(8'h00, dummy);
    spi_byte(8'h00, dummy);
    spi_byte(8'h20, dummy);
    spi_byte(8'h00, dummy);
    for (int i = 0; i < 4; i++) spi_bit(1'b0, m);
    rst_n = 1'b0;
    #1;
    checks++;
    if (all_outs !== 46'd0) begin
      failures++;
      $display("FAIL reset_mid_read_outputs: got %h want 0", all_outs);
    end
    wait_clks(3);
    rst_n = 1'b1;
    clear_log();
    oe_forbid = 1'b1;
    for (int i = 0; i < 8; i++) spi_bit(1'($urandom), m);
    checks++;
    if (rd_q.size() != 0 || wr_q.size() != 0 || cv_q.size() != 0 || oe_bad != 0 || all_outs !== 46'd0) begin
      failures++;
      $display("FAIL reset_ignore_sclk: got rd=%0d wr=%0d cv=%0d outs=%h want 0",
               rd_q.size(), wr_q.size(), cv_q.size(), all_outs);
    end
    spi_end();
    do_read(24'h000020, 3, "reset_recover");
  endtask

  task automatic test_back_to_back();
    logic [23:0] a;
    int n;
    for (int k = 0; k < 8; k++) begin
      a = 24'($urandom);
      if (k % 3 == 0) a = 24'hFFFFFF - 24'($urandom_range(0, 2));
      n = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 0) begin
        do_read(a, n, "rand_read");
      end else begin
        tx_bytes.delete();
        for (int j = 0; j < n; j++) tx_bytes.push_back(8'($urandom));
        do_write(a, "rand_write");
      end
    end
  endtask

  initial begin
    logic [7:0] op;
    test_reset();
    test_read_stream();
    test_write_wrap();
    test_unknown(8'h9F);
    do op = 8'($urandom); while (op == 8'h02 || op == 8'h03);
    test_unknown(op);
    test_abort();
    test_partial_write();
    test_reset_mid_read();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
